// File: rtl/pong_match_ctrl.sv
// Match sequencer for the pong datapath: serve timing, scoring, pause and game-over flow.
// Define DIFF_RAMP_EN to make the computer player harder each time the human scores.
module pong_match_ctrl #(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_DELAY = 50000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause_btn,
  input  logic               miss_left,
  input  logic               miss_right,
  input  logic [1:0]         diff_sel,
  output logic               game_on,
  output logic               ball_reset,
  output logic               ball_serve,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic [1:0]         winner,
  output logic [1:0]         cpu_diff,
  output logic [2:0]         state_o
);

  localparam int TIMER_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    PLAYING    = 3'd2,
    PAUSED     = 3'd3,
    POINT      = 3'd4,
    GAME_OVER  = 3'd5
  } state_t;

  state_t               state, state_nx;
  logic [TIMER_W-1:0]   timer, timer_nx;
  logic [SCORE_W-1:0]   score_l_nx, score_r_nx;
  logic [1:0]           winner_nx, diff_nx;
  logic                 dir_nx, serve_nx, game_on_nx, ball_reset_nx;

  assign state_o = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      score_left  <= '0;
      score_right <= '0;
      winner      <= 2'b00;
      cpu_diff    <= 2'b00;
      serve_dir   <= 1'b0;
      ball_serve  <= 1'b0;
      game_on     <= 1'b0;
      ball_reset  <= 1'b1;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      score_left  <= score_l_nx;
      score_right <= score_r_nx;
      winner      <= winner_nx;
      cpu_diff    <= diff_nx;
      serve_dir   <= dir_nx;
      ball_serve  <= serve_nx;
      game_on     <= game_on_nx;
      ball_reset  <= ball_reset_nx;
    end
  end

  // Motion controls are derived from the next state so they change together with state_o.
  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    score_l_nx = score_left;
    score_r_nx = score_right;
    winner_nx  = winner;
    diff_nx    = cpu_diff;
    dir_nx     = serve_dir;
    serve_nx   = 1'b0;

    case (state)
      IDLE, GAME_OVER: begin
        if (start) begin
          score_l_nx = '0;
          score_r_nx = '0;
          winner_nx  = 2'b00;
          diff_nx    = diff_sel;
          dir_nx     = 1'b0;
          timer_nx   = TIMER_LOAD;
          state_nx   = SERVE_WAIT;
        end
      end
      SERVE_WAIT: begin
        if (timer == '0) begin
          serve_nx = 1'b1;
          state_nx = PLAYING;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      PLAYING: begin
        if (miss_left && miss_right) begin
          dir_nx   = ~serve_dir;
          state_nx = POINT;
        end else if (miss_left) begin
          score_r_nx = score_right + 1'b1;
          dir_nx     = 1'b0;
          state_nx   = POINT;
        end else if (miss_right) begin
          score_l_nx = score_left + 1'b1;
          dir_nx     = 1'b1;
          state_nx   = POINT;
`ifdef DIFF_RAMP_EN
          if (cpu_diff != 2'b11) diff_nx = cpu_diff + 2'd1;
`endif
        end else if (pause_btn) begin
          state_nx = PAUSED;
        end
      end
      PAUSED: begin
        if (pause_btn) state_nx = PLAYING;
      end
      POINT: begin
        if (score_left == WIN) begin
          winner_nx = 2'b01;
          state_nx  = GAME_OVER;
        end else if (score_right == WIN) begin
          winner_nx = 2'b10;
          state_nx  = GAME_OVER;
        end else begin
          timer_nx = TIMER_LOAD;
          state_nx = SERVE_WAIT;
        end
      end
      default: state_nx = IDLE;
    endcase

    game_on_nx    = (state_nx == SERVE_WAIT) || (state_nx == PLAYING);
    ball_reset_nx = (state_nx != PLAYING) && (state_nx != PAUSED);
  end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match sequencer for the pong datapath: owns the serve/score/game-over flow.
- Drives game_on to both paddle instances (human and computer player) and the ball; drives serve/reset controls to the ball.
- Keeps scores and delivers the difficulty setting to the computer player.
- Consumes miss pulses from the ball block; all outputs registered.

Parameters:
SCORE_W, 4, width of each score counter
WIN_SCORE, 11, points that end the match; must be < 2**SCORE_W
SERVE_DELAY, 50000000, cycles spent in SERVE_WAIT before launch; >= 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; begins a match
pause_btn  input  1  single-cycle pulse; toggles pause
miss_left  input  1  pulse from ball block: ball passed left paddle
miss_right  input  1  pulse from ball block: ball passed right paddle
diff_sel  input  2  difficulty, latched on match start
game_on  output  1  enables paddle/ball motion
ball_reset  output  1  holds ball at centre while high
ball_serve  output  1  one-cycle launch pulse to ball
serve_dir  output  1  0 = launch toward left, 1 = toward right
score_left  output  SCORE_W  left player points
score_right  output  SCORE_W  right player points
winner  output  2  00 none, 01 left, 10 right
cpu_diff  output  2  difficulty to computer player
state_o  output  3  current state encoding, for debug/LEDs

Behaviour:
- States and encoding: IDLE=0, SERVE_WAIT=1, PLAYING=2, PAUSED=3, POINT=4, GAME_OVER=5.
- Reset (reset low, asynchronous) sets every output and register as follows; reset mid-match aborts immediately:
  - state IDLE, scores 0, winner 00, cpu_diff 00, timer 0
  - game_on 0, ball_reset 1, ball_serve 0, serve_dir 0
- Outputs per state:
  - IDLE, GAME_OVER: game_on 0, ball_reset 1
  - SERVE_WAIT: game_on 1, ball_reset 1 (paddles move, ball parked)
  - PLAYING: game_on 1, ball_reset 0
  - PAUSED: game_on 0, ball_reset 0 (ball frozen in place)
  - POINT: game_on 0, ball_reset 1
- IDLE or GAME_OVER + start:
  - scores cleared, winner 00, diff_sel latched into cpu_diff, serve_dir 0
  - timer loaded SERVE_DELAY-1; next state SERVE_WAIT
- start is ignored in all other states.
- SERVE_WAIT: timer decrements each cycle. When timer==0, next state is PLAYING and ball_serve is 1 for exactly the first PLAYING cycle. SERVE_WAIT therefore lasts exactly SERVE_DELAY cycles.
- PLAYING, evaluated in this priority order:
  - miss_left only: score_right +1, serve_dir 0, go to POINT
  - miss_right only: score_left +1, serve_dir 1, go to POINT
  - both misses in the same cycle: no score change, serve_dir inverted, go to POINT (replay)
  - pause_btn with no miss: go to PAUSED
- PAUSED: miss inputs ignored; pause_btn returns to PLAYING with no re-serve.
- pause_btn is ignored outside PLAYING/PAUSED.
- POINT lasts one cycle:
  - if score_left==WIN_SCORE: winner 01, go to GAME_OVER
  - else if score_right==WIN_SCORE: winner 10, go to GAME_OVER
  - else: timer loaded SERVE_DELAY-1, go to SERVE_WAIT
- Scores never exceed WIN_SCORE (the match ends on reaching it); no wrap. Scores and winner hold in GAME_OVER until start.
- Timer width is clog2(SERVE_DELAY), with a minimum of 1 bit.

Optional Feature:
DIFF_RAMP_EN
- Defined: each time score_left increments (human scores), cpu_diff increments by 1 in the same cycle, saturating at 11. Reloaded from diff_sel on start.
- Undefined: cpu_diff holds the value latched at start for the whole match.

Test Plan:
(All scenarios with SERVE_DELAY=4, WIN_SCORE=3.)
1. Reset low mid-PLAYING with score 2-1 -> all outputs at reset values asynchronously; state_o=0.
2. start, diff_sel=10 -> SERVE_WAIT 4 cycles, game_on=1, ball_reset=1; then ball_serve high 1 cycle, ball_reset=0, cpu_diff=10.
3. In PLAYING, miss_right three times, each rally re-served -> score_left 1,2,3; after the third POINT, winner=01, state_o=5, game_on=0.
4. miss_left and miss_right in the same cycle with serve_dir=1 -> scores unchanged, serve_dir=0, re-serve after 4 cycles.
5. pause_btn in PLAYING -> game_on=0, ball_reset=0; miss_left while PAUSED -> ignored; pause_btn -> PLAYING with no ball_serve pulse.
6. DIFF_RAMP_EN defined, diff_sel=10, miss_right twice -> cpu_diff 11 then stays 11; macro undefined -> cpu_diff stays 10.
